// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared types and helpers for the LFSR word generator
package lfsr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HOLD = 2'd2
  } fsm_e;

  localparam int MIN_WIDTH = 4;

  function automatic int clamp_width(input int w);
    return (w < MIN_WIDTH) ? MIN_WIDTH : w;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// rtl/lfsr_step.sv - one combinational Fibonacci/Galois LFSR step
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] state,
  input  logic [W-1:0] taps,
  input  logic         galois,
  output logic [W-1:0] next_state,
  output logic         out_bit,
  output logic         zero_detect
);

  logic fb;

  always_comb begin
    fb          = ^(state & taps);
    zero_detect = (state == '0);
    out_bit     = state[0];
    if (galois) begin
      next_state = (state >> 1) ^ (state[0] ? taps : '0);
    end else begin
      next_state = {fb, state[W-1:1]};
    end
  end

endmodule

// File: rtl/lfsr_prng.sv
// rtl/lfsr_prng.sv - LFSR word generator: FSM, bit packing, stream handshake, counters
module lfsr_prng
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter int               OUT_W        = 8,
  parameter logic [WIDTH-1:0] DEFAULT_TAPS = 16'hB400,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_taps,
  input  logic [WIDTH-1:0] cfg_seed,
  input  logic             cfg_galois,
  input  logic             start,
  input  logic             stop,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [WIDTH-1:0] state_out,
  output logic             lockup,
  output logic [31:0]      word_count
);

  localparam int W  = clamp_width(WIDTH);
  localparam int CW = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  localparam logic [W-1:0]  SEED_W   = W'(DEFAULT_SEED);
  localparam logic [W-1:0]  TAPS_W   = W'(DEFAULT_TAPS);
  localparam logic [CW-1:0] LAST_BIT = CW'(OUT_W - 1);

  fsm_e             fsm_q, fsm_d;
  logic [W-1:0]     state_q, state_d;
  logic [W-1:0]     taps_q, taps_d;
  logic             galois_q, galois_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [OUT_W-1:0] pack_q, pack_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             lockup_q, lockup_d;
  logic [31:0]      word_count_q, word_count_d;

  logic [W-1:0] raw_next;
  logic         raw_bit;
  logic         zero_detect;
  logic [W-1:0] step_next;
  logic         step_bit;
  logic [W-1:0] cfg_seed_w;
  logic [W-1:0] cfg_taps_w;

  lfsr_step #(.W(W)) u_step (
    .state       (state_q),
    .taps        (taps_q),
    .galois      (galois_q),
    .next_state  (raw_next),
    .out_bit     (raw_bit),
    .zero_detect (zero_detect)
  );

  // A zero state can never leave zero, so that step reloads the seed and emits 0.
  always_comb begin
    step_next  = zero_detect ? SEED_W : raw_next;
    step_bit   = zero_detect ? 1'b0 : raw_bit;
    cfg_seed_w = W'(cfg_seed);
    cfg_taps_w = W'(cfg_taps);
  end

  always_comb begin
    fsm_d        = fsm_q;
    state_d      = state_q;
    taps_d       = taps_q;
    galois_d     = galois_q;
    bit_cnt_d    = bit_cnt_q;
    pack_d       = pack_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    lockup_d     = lockup_q;
    word_count_d = word_count_q;

    case (fsm_q)
      ST_IDLE: begin
        if (cfg_we) begin
          taps_d   = cfg_taps_w;
          galois_d = cfg_galois;
          if (cfg_seed_w == '0) begin
            state_d  = SEED_W;
            lockup_d = 1'b1;
          end else begin
            state_d = cfg_seed_w;
          end
        end else if (start) begin
          fsm_d     = ST_FILL;
          bit_cnt_d = '0;
        end
      end

      ST_FILL: begin
        if (stop) begin
          fsm_d     = ST_IDLE;
          bit_cnt_d = '0;
        end else begin
          state_d = step_next;
          if (zero_detect) begin
            lockup_d = 1'b1;
          end
          // First generated bit ends up in the MSB of the word.
          pack_d = OUT_W'({pack_q, step_bit});
          if (bit_cnt_q == LAST_BIT) begin
            out_data_d  = pack_d;
            out_valid_d = 1'b1;
            bit_cnt_d   = '0;
            fsm_d       = ST_HOLD;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

      ST_HOLD: begin
        if (out_valid_q && out_ready) begin
          word_count_d = word_count_q + 32'd1;
          out_valid_d  = 1'b0;
          bit_cnt_d    = '0;
          fsm_d        = ST_FILL;
        end
        if (stop) begin
          out_valid_d = 1'b0;
          bit_cnt_d   = '0;
          fsm_d       = ST_IDLE;
        end
      end

      default: begin
        fsm_d       = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q        <= ST_IDLE;
      state_q      <= SEED_W;
      taps_q       <= TAPS_W;
      galois_q     <= 1'b0;
      bit_cnt_q    <= '0;
      pack_q       <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      lockup_q     <= 1'b0;
      word_count_q <= '0;
    end else begin
      fsm_q        <= fsm_d;
      state_q      <= state_d;
      taps_q       <= taps_d;
      galois_q     <= galois_d;
      bit_cnt_q    <= bit_cnt_d;
      pack_q       <= pack_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      lockup_q     <= lockup_d;
      word_count_q <= word_count_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign busy       = (fsm_q != ST_IDLE);
  assign state_out  = state_q[WIDTH-1:0];
  assign lockup     = lockup_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_lfsr_prng.sv
// tb/tb_lfsr_prng.sv - directed self-checking bench for lfsr_prng (WIDTH=4, OUT_W=4)
module tb_lfsr_prng;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [3:0]  cfg_taps;
  logic [3:0]  cfg_seed;
  logic        cfg_galois;
  logic        start;
  logic        stop;
  logic [3:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic [3:0]  state_out;
  logic        lockup;
  logic [31:0] word_count;

  int total_cnt = 0;
  int bad_cnt   = 0;

  logic [3:0] fib_seq [15] = '{4'b1000, 4'b0100, 4'b0010, 4'b1001, 4'b1100,
                               4'b0110, 4'b1011, 4'b0101, 4'b1010, 4'b1101,
                               4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001};
  logic [3:0] gal_seq [15] = '{4'b1100, 4'b0110, 4'b0011, 4'b1101, 4'b1010,
                               4'b0101, 4'b1110, 4'b0111, 4'b1111, 4'b1011,
                               4'b1001, 4'b1000, 4'b0100, 4'b0010, 4'b0001};

  always #5 clk = ~clk;

  lfsr_prng #(
    .WIDTH        (4),
    .OUT_W        (4),
    .DEFAULT_TAPS (4'b0011),
    .DEFAULT_SEED (4'b1111)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_we     (cfg_we),
    .cfg_taps   (cfg_taps),
    .cfg_seed   (cfg_seed),
    .cfg_galois (cfg_galois),
    .start      (start),
    .stop       (stop),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .state_out  (state_out),
    .lockup     (lockup),
    .word_count (word_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_state"}, 32'(state_out), 32'hF);
    check_eq({tag, "_data"}, 32'(out_data), 32'h0);
    check_eq({tag, "_valid"}, 32'(out_valid), 32'h0);
    check_eq({tag, "_busy"}, 32'(busy), 32'h0);
    check_eq({tag, "_lockup"}, 32'(lockup), 32'h0);
    check_eq({tag, "_wcount"}, word_count, 32'h0);
  endtask

  task automatic configure(input logic [3:0] taps, input logic [3:0] seed, input logic gal);
    cfg_we     = 1'b1;
    cfg_taps   = taps;
    cfg_seed   = seed;
    cfg_galois = gal;
    tick();
    cfg_we = 1'b0;
  endtask

  // Full 15-step period from seed 0001; the HOLD cycles (5, 10, 15) freeze the state.
  task automatic run_period(input logic gal, input string tag);
    int k;
    logic [3:0] exp;
    k         = 0;
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      tick();
      if (c % 5 != 0) begin
        exp = gal ? gal_seq[k] : fib_seq[k];
        check_eq($sformatf("%s_step%0d", tag, k + 1), 32'(state_out), 32'(exp));
        k++;
      end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_eq({tag, "_stop_busy"}, 32'(busy), 32'h0);
  endtask

  initial begin
    reset      = 1'b1;
    cfg_we     = 1'b0;
    cfg_taps   = '0;
    cfg_seed   = '0;
    cfg_galois = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    out_ready  = 1'b0;
    tick();
    tick();
    check_reset_vals("rst");
    reset = 1'b0;
    tick();

    // Default taps/seed, free-running consumer.
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    check_eq("t1_busy", 32'(busy), 32'h1);
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 4) begin
        check_eq("t1_w0_valid", 32'(out_valid), 32'h1);
        check_eq("t1_w0_data", 32'(out_data), 32'hF);
      end
      if (c == 5) begin
        check_eq("t1_w0_drop", 32'(out_valid), 32'h0);
        check_eq("t1_wc1", word_count, 32'd1);
      end
      if (c == 9) check_eq("t1_w1_data", 32'(out_data), 32'h1);
      if (c == 10) check_eq("t1_wc2", word_count, 32'd2);
    end

    // Backpressure on the third word.
    out_ready = 1'b0;
    repeat (4) tick();
    check_eq("t4_valid", 32'(out_valid), 32'h1);
    check_eq("t4_data", 32'(out_data), 32'h3);
    for (int c = 0; c < 20; c++) begin
      tick();
      check_eq("t4_hold_data", 32'(out_data), 32'h3);
      check_eq("t4_hold_state", 32'(state_out), 32'hA);
      check_eq("t4_hold_valid", 32'(out_valid), 32'h1);
      check_eq("t4_hold_wc", word_count, 32'd2);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("t4_accept_wc", word_count, 32'd3);
    check_eq("t4_accept_valid", 32'(out_valid), 32'h0);
    repeat (4) tick();
    check_eq("t4_w3_data", 32'(out_data), 32'h5);
    check_eq("t4_w3_state", 32'(state_out), 32'h7);
    repeat (2) tick();
    check_eq("t4_once_wc", word_count, 32'd3);
    check_eq("t4_once_valid", 32'(out_valid), 32'h1);

    // stop together with acceptance: stop wins, the word still counts.
    stop      = 1'b1;
    out_ready = 1'b1;
    tick();
    stop      = 1'b0;
    out_ready = 1'b0;
    check_eq("t5_acc_wc", word_count, 32'd4);
    check_eq("t5_acc_busy", 32'(busy), 32'h0);
    check_eq("t5_acc_valid", 32'(out_valid), 32'h0);
    check_eq("t5_acc_state", 32'(state_out), 32'h7);

    // stop + start during FILL.
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    stop  = 1'b1;
    start = 1'b1;
    tick();
    stop  = 1'b0;
    start = 1'b0;
    check_eq("t5_busy", 32'(busy), 32'h0);
    check_eq("t5_valid", 32'(out_valid), 32'h0);
    check_eq("t5_state", 32'(state_out), 32'h1);
    tick();
    check_eq("t5_idle_busy", 32'(busy), 32'h0);
    check_eq("t5_idle_state", 32'(state_out), 32'h1);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    out_ready = 1'b0;
    check_eq("t5_next_data", 32'(out_data), 32'h8);
    check_eq("t5_next_state", 32'(state_out), 32'h9);
    check_eq("t5_next_wc", word_count, 32'd4);

    // cfg_we in HOLD is ignored; later steps still use the old taps/mode.
    configure(4'b1111, 4'b0000, 1'b1);
    check_eq("t6_cfg_state", 32'(state_out), 32'h9);
    check_eq("t6_cfg_lockup", 32'(lockup), 32'h0);
    check_eq("t6_cfg_valid", 32'(out_valid), 32'h1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    check_eq("t6_taps_kept", 32'(state_out), 32'hC);
    repeat (3) tick();
    check_eq("t6_hold_valid", 32'(out_valid), 32'h1);
    check_eq("t6_hold_data", 32'(out_data), 32'h9);
    reset = 1'b1;
    tick();
    check_reset_vals("t6_rst");
    reset = 1'b0;

    // cfg_we wins over a simultaneous start; then full periods in both modes.
    start = 1'b1;
    configure(4'b0011, 4'b0001, 1'b0);
    start = 1'b0;
    check_eq("t2_cfg_busy", 32'(busy), 32'h0);
    check_eq("t2_cfg_state", 32'(state_out), 32'h1);
    run_period(1'b0, "t2_fib");
    configure(4'b1100, 4'b0001, 1'b1);
    check_eq("t2_gal_seed", 32'(state_out), 32'h1);
    run_period(1'b1, "t2_gal");

    // Lock-up: zero seed at cfg_we, then zero reached while stepping.
    configure(4'b0011, 4'b0000, 1'b0);
    check_eq("t3_seed0_state", 32'(state_out), 32'hF);
    check_eq("t3_seed0_lockup", 32'(lockup), 32'h1);
    configure(4'b0000, 4'b0001, 1'b0);
    check_eq("t3_cfg_state", 32'(state_out), 32'h1);
    out_ready = 1'b0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check_eq("t3_step1", 32'(state_out), 32'h0);
    tick();
    check_eq("t3_step2_recover", 32'(state_out), 32'hF);
    check_eq("t3_step2_lockup", 32'(lockup), 32'h1);
    tick();
    check_eq("t3_step3", 32'(state_out), 32'h7);
    tick();
    check_eq("t3_step4", 32'(state_out), 32'h3);
    check_eq("t3_word", 32'(out_data), 32'hB);
    check_eq("t3_valid", 32'(out_valid), 32'h1);
    check_eq("t3_lockup_sticky", 32'(lockup), 32'h1);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/lfsr_prng.md
# lfsr_prng

Parametrised pseudo-random word generator for the Nios/Qsys fabric. It is the successor to the fixed-feedback 4+ bit LFSR, and adds:
- programmable width and tap mask
- Fibonacci or Galois mode
- seed load
- packing of OUT_W generated bits per output word, delivered over a valid/ready stream
- lock-up recovery with a sticky flag

It sits between a CPU-side configuration register bank and any stream consumer (test-pattern generators, dither, scramblers).

## Interface
- WIDTH, 16: LFSR state width; values below 4 are forced to 4.
- OUT_W, 8: bits per output word; legal range 1..WIDTH.
- DEFAULT_TAPS, 16'hB400: tap mask loaded at reset.
- DEFAULT_SEED, all ones: seed loaded at reset and used for lock-up recovery.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high.
- cfg_we  in  1  load cfg_taps, cfg_seed and cfg_galois; accepted only in IDLE.
- cfg_taps  in  WIDTH  tap mask.
- cfg_seed  in  WIDTH  new state.
- cfg_galois  in  1  0 = Fibonacci, 1 = Galois.
- start  in  1  begin generating (pulse).
- stop  in  1  abort generation (pulse).
- out_data  out  OUT_W  packed word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the word.
- busy  out  1  FSM is not in IDLE.
- state_out  out  WIDTH  current LFSR state.
- lockup  out  1  sticky flag: zero state was detected and recovered.
- word_count  out  32  number of accepted words; wraps modulo 2^32.

## Operation
FSM states:
- IDLE
  - busy = 0; the LFSR does not step.
  - cfg_we writes the taps, mode and state registers.
  - If cfg_we and start arrive in the same cycle, cfg_we wins and start is ignored.
  - start alone moves to FILL, with bit counter = 0.
- FILL
  - One LFSR step per cycle.
  - The output bit is state[0] taken before the step. It is shifted into the pack register LSB-first-in: pack <= {pack[OUT_W-2:0], bit}, so the first generated bit ends up in the MSB.
  - After the OUT_W-th step, pack is copied to out_data, out_valid is asserted and the FSM moves to HOLD.
- HOLD
  - The LFSR is frozen; out_data is held stable.
  - out_valid && out_ready: the word is accepted, word_count increments, out_valid drops next cycle and the FSM returns to FILL.

stop in FILL or HOLD:
- Next state is IDLE, out_valid = 0, any partial word is discarded.
- LFSR state is retained.
- stop wins over start and over acceptance in the same cycle; a word accepted in that same cycle is still counted.

Step functions:
- Fibonacci: fb = ^(state & taps); next = {fb, state[WIDTH-1:1]}.
- Galois: next = (state >> 1) ^ (state[0] ? taps : 0).

Lock-up handling:
- If state == 0 at any step, or at cfg_we with cfg_seed == 0, the state is loaded with DEFAULT_SEED instead and lockup sets.
- In the step case, the recovery consumes that step and emits bit 0.
- lockup clears only on reset.

cfg_we outside IDLE is ignored entirely.

## Timing
Reset values:
- state = DEFAULT_SEED
- taps = DEFAULT_TAPS
- mode = Fibonacci
- FSM = IDLE
- out_data = 0, out_valid = 0, busy = 0
- lockup = 0, word_count = 0

Latency and throughput:
- start accepted at edge N → first step at edge N+1 → out_valid high after edge N+OUT_W.
- With out_ready held at 1, a word is produced every OUT_W+1 cycles.
- state_out is registered and reflects the most recent step.
- cfg_we takes effect at the next edge; state_out shows the new seed one cycle after cfg_we.
- out_valid must not drop without acceptance, except on stop or reset.
- Reset mid-FILL or mid-HOLD restores all reset values in one cycle.

## Structure
- Package lfsr_pkg:
  - FSM enum (IDLE, FILL, HOLD)
  - MIN_WIDTH = 4
  - function clamp_width
- Sub-module lfsr_step, purely combinational:
  - inputs: state, taps, galois
  - outputs: next state, out_bit, zero_detect
- The top level contains the FSM, the pack register, the handshake logic and the counters.

## Test plan
1. WIDTH=4, OUT_W=4, taps 4'b0011, Fibonacci, default seed 4'b1111, out_ready=1, start → words 4'b1111 then 4'b0001. word_count reaches 2 after those two handshakes, 10 cycles after start.
2. WIDTH=4, Fibonacci taps 4'b0011, then Galois taps 4'b1100, each with seed 4'b0001 and 15 steps → state_out visits 15 distinct nonzero values and returns to 4'b0001 on step 15.
3. cfg_we with cfg_seed=0 → state_out = 4'b1111, lockup=1. Then taps=0 with seed 4'b0001, 4 steps → state reaches zero and recovers to the seed, lockup remains 1.
4. Backpressure: out_ready=0 for 20 cycles while valid → out_data stable, state_out frozen, word_count unchanged. Release out_ready → exactly one acceptance.
5. stop during FILL with start asserted in the same cycle → IDLE next cycle, busy=0, out_valid=0. State is retained, and the next start's first word continues the sequence from the retained state.
6. cfg_we during HOLD → ignored (taps and state unchanged). Reset asserted in HOLD → every output returns to its reset value in one cycle.
